// File: rtl/alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// alu_cmd_seq
//   Command sequencer placed directly upstream of a 4-bit combinational ALU.
//   Commands {a, b, c, op, chain} are buffered in a DEPTH-entry FIFO. The FIFO
//   head drives the ALU operand/opcode inputs. When the result register is
//   free, or is being consumed, the ALU answer is captured into res_data and
//   into the accumulator acc. A chained command takes acc as operand A.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready = FIFO not full)
//   cmd_a/b/c/op/chain    command fields
//   alu_a/b/c/op          combinational drive to the ALU (all 0 when empty)
//   alu_ans               ALU answer
//   res_valid/res_ready   result handshake; res_data is registered
//   count                 FIFO occupancy
//   issued                executed-command counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module alu_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_a,
  input  logic [3:0]    cmd_b,
  input  logic [1:0]    cmd_c,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_chain,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [1:0]    alu_c,
  output logic [1:0]    alu_op,
  input  logic [3:0]    alu_ans,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_data,
  output logic [CW-1:0] count,
  output logic [7:0]    issued
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry layout: [12:9] a, [8:5] b, [4:3] c, [2:1] op, [0] chain
  logic [12:0]   mem_q [DEPTH];
  logic [12:0]   head;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [3:0]    res_data_q, res_data_d;
  logic [3:0]    acc_q, acc_d;
  logic [7:0]    issued_q, issued_d;

  logic          occupied;
  logic          push;
  logic          fire;

  assign occupied  = (count_q != '0);
  // Readiness looks only at occupancy so a full FIFO refuses even while popping.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign fire      = occupied && (!res_valid_q || res_ready);
  assign head      = mem_q[rptr_q];

  // Head decode: chained entries substitute the accumulator for operand A.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_c  = '0;
    alu_op = '0;
    if (occupied) begin
      alu_a  = head[0] ? acc_q : head[12:9];
      alu_b  = head[8:5];
      alu_c  = head[4:3];
      alu_op = head[2:1];
    end
  end

  // Next-state for pointers, occupancy, result register and accumulator.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    acc_d       = acc_q;
    issued_d    = issued_q;

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end

    if (fire) begin
      rptr_d      = rptr_q + 1'b1;
      res_valid_d = 1'b1;
      res_data_d  = alu_ans;
      acc_d       = alu_ans;
      issued_d    = issued_q + 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    if (push && !fire) begin
      count_d = count_q + 1'b1;
    end else if (fire && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      acc_q       <= '0;
      issued_q    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      acc_q       <= acc_d;
      issued_q    <= issued_d;
    end
  end

  // Storage carries no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {cmd_a, cmd_b, cmd_c, cmd_op, cmd_chain};
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign count     = count_q;
  assign issued    = issued_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_seq
//   Bench for alu_cmd_seq with a behavioural ALU attached to the alu_* ports.
//   Each accepted command pushes its expected result into a scoreboard queue;
//   a monitor pops and compares whenever a result is handed off downstream.
// -----------------------------------------------------------------------------
module tb_alu_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [1:0]    cmd_c;
  logic [1:0]    cmd_op;
  logic          cmd_chain;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [1:0]    alu_c;
  logic [1:0]    alu_op;
  logic [3:0]    alu_ans;
  logic          res_valid;
  logic          res_ready;
  logic [3:0]    res_data;
  logic [CW-1:0] count;
  logic [7:0]    issued;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  logic [3:0] model_acc = 4'd0;
  logic [7:0] model_issued = 8'd0;

  always #5 clk = ~clk;

  alu_cmd_seq #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .cmd_op    (cmd_op),
    .cmd_chain (cmd_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_op    (alu_op),
    .alu_ans   (alu_ans),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .count     (count),
    .issued    (issued)
  );

  // Reference arithmetic on plain integers.
  function automatic logic [3:0] ref_alu(input int a, input int b, input int c, input int op);
    int s;
    int r;
    case (op)
      0: begin
        s = (a >= 8) ? a - 16 : a;
        r = s >>> c;
      end
      1: r = a / (1 << c);
      2: r = a - b;
      default: r = a + b;
    endcase
    return 4'(r & 15);
  endfunction

  // The combinational ALU the sequencer drives.
  always_comb begin
    alu_ans = ref_alu(int'(alu_a), int'(alu_b), int'(alu_c), int'(alu_op));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: a result seen with res_ready high is consumed on the next edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none at %0t", res_data, $time);
      end else begin
        check("res_data", int'(res_data), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic drive(input bit v, input int a, input int b, input int c, input int op,
                       input bit ch, input bit rr, output bit ok);
    logic [3:0] a_eff;
    logic [3:0] r;
    cmd_valid = v;
    cmd_a     = 4'(a);
    cmd_b     = 4'(b);
    cmd_c     = 2'(c);
    cmd_op    = 2'(op);
    cmd_chain = ch;
    res_ready = rr;
    ok = v && cmd_ready;
    @(posedge clk);
    if (ok) begin
      a_eff = ch ? model_acc : 4'(a);
      r = ref_alu(int'(a_eff), b & 15, c & 3, op & 3);
      model_acc = r;
      exp_q.push_back(r);
      model_issued = model_issued + 8'd1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit done;
    bit ok;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (count == '0 && !res_valid) begin
        done = 1'b1;
        break;
      end
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, ok);
    end
    check("drain_done", int'(done), 1);
    check("issued", int'(issued), int'(model_issued));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int accepted;
    int guard;
    logic [3:0] h_res, h_a, h_b;
    logic [1:0] h_c, h_op;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_op = '0; cmd_chain = 1'b0;
    res_ready = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_issued", int'(issued), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_alu_a", int'(alu_a), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single add with one-cycle latency.
    drive(1'b1, 3, 4, 0, 3, 1'b0, 1'b1, ok);
    check("add_accepted", int'(ok), 1);
    check("add_res_valid_early", int'(res_valid), 0);
    check("add_count1", int'(count), 1);
    check("add_alu_a", int'(alu_a), 3);
    check("add_alu_b", int'(alu_b), 4);
    check("add_alu_op", int'(alu_op), 3);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, ok);
    check("add_res_valid", int'(res_valid), 1);
    check("add_res_data", int'(res_data), 7);
    check("add_issued", int'(issued), 1);
    check("add_count0", int'(count), 0);
    drain();

    // Wrap-around add and both shifts, back to back.
    drive(1'b1, 9, 9, 0, 3, 1'b0, 1'b1, ok);
    drive(1'b1, 8, 0, 2, 0, 1'b0, 1'b1, ok);
    check("wrap_res", int'(res_data), 2);
    drive(1'b1, 8, 0, 2, 1, 1'b0, 1'b1, ok);
    check("sra_res", int'(res_data), 14);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, ok);
    check("srl_res", int'(res_data), 2);
    drain();

    // Chained commands reuse the previous result.
    drive(1'b1, 3, 4, 0, 3, 1'b0, 1'b1, ok);
    drive(1'b1, 15, 1, 0, 2, 1'b1, 1'b1, ok);
    drive(1'b1, 15, 0, 1, 1, 1'b1, 1'b1, ok);
    check("chain_sub", int'(res_data), 6);
    drain();
    check("chain_srl", int'(res_data), 3);
    drive(1'b1, 0, 0, 0, 3, 1'b1, 1'b1, ok);
    drain();
    check("chain_acc", int'(res_data), 3);

    // Fill under backpressure.
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, $urandom_range(15), $urandom_range(15), $urandom_range(3),
            $urandom_range(3), 1'($urandom_range(1)), 1'b0, ok);
      accepted += int'(ok);
    end
    check("full_accepted", accepted, 5);
    check("full_count", int'(count), DEPTH);
    check("full_cmd_ready", int'(cmd_ready), 0);
    check("full_res_valid", int'(res_valid), 1);
    h_res = res_data; h_a = alu_a; h_b = alu_b; h_c = alu_c; h_op = alu_op;
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, ok);
    check("hold_res_data", int'(res_data), int'(h_res));
    check("hold_alu_a", int'(alu_a), int'(h_a));
    check("hold_alu_b", int'(alu_b), int'(h_b));
    check("hold_alu_c", int'(alu_c), int'(h_c));
    check("hold_alu_op", int'(alu_op), int'(h_op));
    check("hold_count", int'(count), DEPTH);
    drain();

    // Asynchronous reset in the middle of activity.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom_range(15), $urandom_range(15), $urandom_range(3),
            $urandom_range(3), 1'b0, 1'b0, ok);
    end
    check("pre_rst_count", int'(count), 3);
    check("pre_rst_res_valid", int'(res_valid), 1);
    #3 reset = 1'b1;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_res_data", int'(res_data), 0);
    check("arst_issued", int'(issued), 0);
    check("arst_alu_a", int'(alu_a), 0);
    check("arst_cmd_ready", int'(cmd_ready), 1);
    exp_q.delete();
    model_acc = 4'd0;
    model_issued = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 15, 5, 0, 3, 1'b1, 1'b1, ok);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, ok);
    check("post_rst_chain", int'(res_data), 5);
    drain();

    // Random traffic until the execution counter reaches 255, then wrap it.
    guard = 0;
    while (model_issued != 8'd255 && guard < 5000) begin
      drive(($urandom_range(3) != 0), $urandom_range(15), $urandom_range(15),
            $urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
            ($urandom_range(9) < 7), ok);
      guard++;
    end
    drain();
    check("issued_255", int'(issued), 255);
    drive(1'b1, $urandom_range(15), $urandom_range(15), $urandom_range(3),
          $urandom_range(3), 1'($urandom_range(1)), 1'b1, ok);
    drain();
    check("issued_wrap", int'(issued), 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
Name: alu_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the 4-bit combinational ALU (ops: arithmetic shift right, logical shift right, subtract, add).
- Buffers operand/opcode commands in a small FIFO and drives the ALU operand/opcode inputs from the FIFO head.
- Captures the ALU result into a registered output with a valid/ready handshake.
- Supports chained commands, where operand A is the previous result.

Parameters:
- DEPTH, 4, command FIFO depth; power of 2, minimum 2.
- CW, 3, width of count output; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_c  input  2  shift amount.
- cmd_op  input  2  opcode: 00 sra, 01 srl, 10 A-B, 11 A+B.
- cmd_chain  input  1  1: use last captured result as A and ignore cmd_a.
- alu_a  output  4  to ALU inA.
- alu_b  output  4  to ALU inB.
- alu_c  output  2  to ALU inC.
- alu_op  output  2  to ALU op.
- alu_ans  input  4  from ALU ans.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  4  registered result.
- count  output  CW  number of FIFO entries.
- issued  output  8  total commands executed; wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, immediate):
  - count=0, read/write pointers=0, res_valid=0, res_data=0, accumulator acc=0, issued=0.
  - Any in-flight commands and results are discarded.
- Push: cmd_valid && cmd_ready at a rising edge writes {a,b,c,op,chain} at wptr; wptr increments mod DEPTH.
- cmd_ready = (count != DEPTH).
  - Readiness does not depend on a same-cycle pop, so a full FIFO deasserts ready even while popping.
- ALU drive (combinational from the FIFO head):
  - alu_a = head.chain ? acc : head.a.
  - alu_b, alu_c, alu_op come from head fields.
  - When count==0, all alu_* outputs are 0.
- Fire condition: fire = (count!=0) && (!res_valid || res_ready).
- On a firing edge:
  - res_data<=alu_ans, acc<=alu_ans, res_valid<=1.
  - rptr increments mod DEPTH; issued increments.
- On a non-firing edge: if res_valid && res_ready then res_valid<=0. res_data and acc hold.
- Simultaneous push and fire: count unchanged; both pointers advance.
- Empty FIFO with cmd_valid: the entry is written this edge; the earliest fire is the next cycle. No bypass.
- Latency:
  - Command accepted at edge N, FIFO empty, output free: res_valid=1 after edge N+1.
  - Throughput is one result per cycle when res_ready is held 1.
- Chain hazard:
  - acc updates on the same edge a command fires.
  - A chained command at the head in the following cycle sees the new acc.
  - No stall is required.
- Backpressure: while res_valid=1 and res_ready=0, res_data, acc, the head and the alu_* outputs hold stable; the FIFO may keep filling.
- Arithmetic is the ALU's: 4-bit wrap-around on add/sub; sra sign-fills from bit 3. The block adds no arithmetic of its own.
- acc persists across idle periods; only reset clears it.

Test Plan:
- Single add: reset, push a=3,b=4,op=11, res_ready=1.
  -> res_valid=1 one cycle after acceptance with res_data=7; issued=1; count back to 0.
- Wrap and shift: push a=9,b=9,op=11; then a=8,c=2,op=00; then a=8,c=2,op=01.
  -> results 2, 4'b1110, 4'b0010 on consecutive cycles.
- Chain: push a=3,b=4,op=11; then chain=1,b=1,op=10; then chain=1,c=1,op=01.
  -> results 7, 6, 3 back-to-back; acc=3 at end.
- Full/backpressure: hold res_ready=0 and push 6 commands.
  -> first fires into res_data; cmd_ready drops after count=4; 5 accepted in total.
  -> releasing res_ready drains the remaining 4 results in order, one per cycle, then count=0.
- Reset mid-operation: assert reset asynchronously between edges with count=3 and res_valid=1.
  -> all outputs 0 immediately; a chained command pushed after release uses acc=0.
- Counter wrap: execute 256 commands.
  -> issued reads 255 then 0.
